// File: rtl/ewb_multi.sv
// Eviction write buffer between L2 and physical memory: DEPTH-entry circular FIFO of
// dirty lines with in-place coalescing, read-hit forwarding and background draining.
module ewb_multi #(
   parameter int DEPTH    = 4,
   parameter int LINE_W   = 256,
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [ADDR_W-1:0]            mem_address,
   input  logic [LINE_W-1:0]            mem_wdata,
   output logic [LINE_W-1:0]            mem_rdata,
   output logic                         mem_resp,
   output logic                         pmem_read,
   output logic                         pmem_write,
   output logic [ADDR_W-1:0]            pmem_address,
   output logic [LINE_W-1:0]            pmem_wdata,
   input  logic [LINE_W-1:0]            pmem_rdata,
   input  logic                         pmem_resp,
   output logic [$clog2(DEPTH+1)-1:0]   ewb_count,
   output logic                         ewb_full,
   output logic                         ewb_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR_ACK = 3'd1,
      S_RD_HIT = 3'd2,
      S_RD_MEM = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   state_t              r_state;
   logic [DEPTH-1:0]    r_valid;
   logic [ADDR_W-1:0]   r_addr [DEPTH];
   logic [LINE_W-1:0]   r_data [DEPTH];
   logic [PTR_W-1:0]    r_head;
   logic [PTR_W-1:0]    r_tail;
   logic [CNT_W-1:0]    r_count;
   logic                r_full;
   logic                r_empty;
   logic [LINE_W-1:0]   r_rd_data;

   logic [ADDR_W-1:0]   w_line_addr;
   logic [DEPTH-1:0]    w_hit_vec;
   logic                w_hit;
   logic [PTR_W-1:0]    w_hit_idx;
   logic                w_req_rd;
   logic                w_req_wr;
   logic                w_wr_hit;
   logic                w_push;

   assign w_line_addr = mem_address & ~OFF_MASK;

   // Address match; coalescing keeps at most one valid entry per line, so OR-encoding the index is safe.
   always_comb begin
      w_hit_vec = {DEPTH{1'b0}};
      w_hit_idx = {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         w_hit_vec[i] = r_valid[i] && (r_addr[i] == w_line_addr);
         w_hit_idx    = w_hit_idx | (w_hit_vec[i] ? PTR_W'(i) : {PTR_W{1'b0}});
      end
      w_hit = |w_hit_vec;
   end

   assign w_req_rd = (r_state == S_IDLE) && mem_read;
   assign w_req_wr = (r_state == S_IDLE) && !mem_read && mem_write;
   assign w_wr_hit = w_req_wr && w_hit;
   assign w_push   = w_req_wr && !w_hit && !r_full;

   // Control FSM, pointers, occupancy and valid bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_valid <= {DEPTH{1'b0}};
         r_head  <= {PTR_W{1'b0}};
         r_tail  <= {PTR_W{1'b0}};
         r_count <= {CNT_W{1'b0}};
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mem_read) begin
                  r_state <= w_hit ? S_RD_HIT : S_RD_MEM;
               end else if (mem_write) begin
                  if (w_hit) begin
                     r_state <= S_WR_ACK;
                  end else if (!r_full) begin
                     r_valid[r_tail] <= 1'b1;
                     r_tail          <= r_tail + PTR_W'(1);
                     r_count         <= r_count + CNT_W'(1);
                     r_full          <= (r_count == CNT_W'(DEPTH - 1));
                     r_empty         <= 1'b0;
                     r_state         <= S_WR_ACK;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end else if (!r_empty) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_WR_ACK: r_state <= S_IDLE;
            S_RD_HIT: r_state <= S_IDLE;
            S_RD_MEM: r_state <= pmem_resp ? S_IDLE : S_RD_MEM;
            S_DRAIN: begin
               if (pmem_resp) begin
                  r_valid[r_head] <= 1'b0;
                  r_head          <= r_head + PTR_W'(1);
                  r_count         <= r_count - CNT_W'(1);
                  r_full          <= 1'b0;
                  r_empty         <= (r_count == CNT_W'(1));
                  r_state         <= S_IDLE;
               end else begin
                  r_state <= S_DRAIN;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Line storage and read-hit latch; contents are meaningless until the valid bit says otherwise.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= w_line_addr;
         r_data[r_tail] <= mem_wdata;
      end
      if (w_wr_hit) begin
         r_data[w_hit_idx] <= mem_wdata;
      end
      if (w_req_rd && w_hit) begin
         r_rd_data <= r_data[w_hit_idx];
      end
   end

   // Output decode; the miss path passes memory data and handshake straight through.
   always_comb begin
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = w_line_addr;
      mem_rdata    = pmem_rdata;
      pmem_wdata   = r_data[r_head];
      case (r_state)
         S_WR_ACK: mem_resp = 1'b1;
         S_RD_HIT: begin
            mem_resp  = 1'b1;
            mem_rdata = r_rd_data;
         end
         S_RD_MEM: begin
            pmem_read = 1'b1;
            mem_resp  = pmem_resp;
         end
         S_DRAIN: begin
            pmem_write   = 1'b1;
            pmem_address = r_addr[r_head];
         end
         default: mem_resp = 1'b0;
      endcase
   end

   assign ewb_count = r_count;
   assign ewb_full  = r_full;
   assign ewb_empty = r_empty;

endmodule

// File: tb/tb_ewb_multi.sv
// Bench for ewb_multi: transaction-level model (FIFO of lines plus backing memory)
// drives directed and random cache traffic and a memory responder with variable latency.
module tb_ewb_multi;
   localparam int DEPTH    = 4;
   localparam int LINE_W   = 256;
   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = 5;
   localparam int CW       = $clog2(DEPTH + 1);
   localparam logic [31:0] ALIGN = 32'hFFFF_FFE0;

   logic              clk = 1'b0;
   logic              reset;
   logic              mem_read, mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata, mem_rdata;
   logic              mem_resp;
   logic              pmem_read, pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata, pmem_rdata;
   logic              pmem_resp;
   logic [CW-1:0]     ewb_count;
   logic              ewb_full, ewb_empty;

   always #5 clk = ~clk;

   ewb_multi #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) dut (
      .clk(clk), .reset(reset),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .ewb_count(ewb_count), .ewb_full(ewb_full), .ewb_empty(ewb_empty)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: buffered lines oldest-first, and what memory holds.
   logic [31:0]       addr_q[$];
   logic [LINE_W-1:0] data_q[$];
   logic [LINE_W-1:0] mem_m [logic [31:0]];
   int                lat     = 1;
   int                lat_cnt = 0;
   bit                cur_wr  = 1'b0;
   bit                gap     = 1'b0;

   task automatic check_eq(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] mem_val(input logic [31:0] la);
      if (mem_m.exists(la)) return mem_m[la];
      return {8{la ^ 32'h5A5A_0000}};
   endfunction

   function automatic int find_q(input logic [31:0] la);
      foreach (addr_q[i]) if (addr_q[i] == la) return i;
      return -1;
   endfunction

   function automatic logic [LINE_W-1:0] rnd_line();
      logic [LINE_W-1:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk_occ();
      check_eq("count", LINE_W'(ewb_count), LINE_W'(addr_q.size()));
      check_eq("full",  LINE_W'(ewb_full),  LINE_W'(addr_q.size() == DEPTH));
      check_eq("empty", LINE_W'(ewb_empty), LINE_W'(addr_q.size() == 0));
   endtask

   // One clock: memory responder acts #1 after the edge, outputs are settled by #2.
   task automatic tick();
      bit req_e;
      @(posedge clk);
      #1;
      req_e = mem_read | mem_write;
      if (pmem_resp) begin
         pmem_resp = 1'b0;
         lat_cnt   = 0;
         if (cur_wr && addr_q.size() > 0) begin
            mem_m[addr_q[0]] = data_q[0];
            void'(addr_q.pop_front());
            void'(data_q.pop_front());
            gap = 1'b1;
         end
      end else begin
         if (gap && !req_e && addr_q.size() > 0)
            check_eq("drain_b2b", LINE_W'(pmem_write), LINE_W'(1));
         gap = 1'b0;
         if (pmem_read) begin
            check_eq("rd_addr", LINE_W'(pmem_address), LINE_W'(mem_address & ALIGN));
            check_eq("rd_not_buffered", LINE_W'(find_q(pmem_address) < 0), LINE_W'(1));
         end
         if (pmem_read || pmem_write) begin
            lat_cnt++;
            if (lat_cnt >= lat) begin
               pmem_resp = 1'b1;
               if (pmem_write) begin
                  cur_wr = 1'b1;
                  check_eq("drain_expected", LINE_W'(addr_q.size() > 0), LINE_W'(1));
                  if (addr_q.size() > 0) begin
                     check_eq("drain_addr", LINE_W'(pmem_address), LINE_W'(addr_q[0]));
                     check_eq("drain_data", pmem_wdata, data_q[0]);
                  end
               end else begin
                  cur_wr     = 1'b0;
                  pmem_rdata = mem_val(pmem_address);
               end
            end
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk_occ();
      end
   endtask

   task automatic wait_empty();
      int n = 0;
      while (addr_q.size() > 0 && n < 1000) begin
         tick();
         chk_occ();
         n++;
      end
      check_eq("drained", LINE_W'(addr_q.size()), LINE_W'(0));
   endtask

   // One cache request; latency is predicted only when memory is quiet at issue.
   task automatic do_req(input bit wr, input logic [31:0] a, input logic [LINE_W-1:0] d, input int new_lat);
      bit                idle_now;
      bit                got;
      int                n;
      int                exp_lat;
      int                idx;
      logic [31:0]       la;
      logic [LINE_W-1:0] exp_d;
      idle_now = !(pmem_read || pmem_write || pmem_resp);
      if (idle_now) lat = new_lat;
      la  = a & ALIGN;
      idx = find_q(la);
      if (!wr) exp_lat = (idx >= 0) ? 1 : lat;
      else     exp_lat = (idx >= 0 || addr_q.size() < DEPTH) ? 1 : lat + 2;
      mem_address = a;
      mem_wdata   = d;
      mem_read    = !wr;
      mem_write   = wr;
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         tick();
         n++;
         if (mem_resp) got = 1'b1;
         else chk_occ();
      end
      check_eq(wr ? "wr_resp_seen" : "rd_resp_seen", LINE_W'(got), LINE_W'(1));
      if (got && idle_now) check_eq(wr ? "wr_latency" : "rd_latency", LINE_W'(n), LINE_W'(exp_lat));
      if (got) begin
         idx = find_q(la);
         if (!wr) begin
            exp_d = (idx >= 0) ? data_q[idx] : mem_val(la);
            check_eq("rd_data", mem_rdata, exp_d);
         end else if (idx >= 0) begin
            data_q[idx] = d;
         end else begin
            addr_q.push_back(la);
            data_q.push_back(d);
         end
         chk_occ();
         tick();
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk_occ();
   endtask

   initial begin
      logic [LINE_W-1:0] d_a, d_b;
      int                n;
      reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = 32'h0;
      mem_wdata = {LINE_W{1'b0}}; pmem_rdata = {LINE_W{1'b0}}; pmem_resp = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_empty", LINE_W'(ewb_empty), LINE_W'(1));
      check_eq("rst_full",  LINE_W'(ewb_full),  LINE_W'(0));
      check_eq("rst_resp",  LINE_W'(mem_resp),  LINE_W'(0));
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("idle_no_pmem", LINE_W'(pmem_read | pmem_write), LINE_W'(0));
         chk_occ();
      end

      // Fill with memory stalled, then a fifth write forces a drain of the oldest.
      do_req(1'b1, 32'h100, rnd_line(), 1000);
      do_req(1'b1, 32'h200, rnd_line(), 1000);
      do_req(1'b1, 32'h300, rnd_line(), 1000);
      do_req(1'b1, 32'h400, rnd_line(), 1000);
      do_req(1'b1, 32'h500, rnd_line(), 3);
      check_eq("full_after_5th", LINE_W'(ewb_count), LINE_W'(4));
      wait_empty();

      // Coalesce: one drain carrying the second data.
      d_a = rnd_line();
      d_b = rnd_line();
      do_req(1'b1, 32'h200, d_a, 2);
      do_req(1'b1, 32'h210, d_b, 2);
      check_eq("coalesce_count", LINE_W'(ewb_count), LINE_W'(1));
      wait_empty();
      do_req(1'b0, 32'h200, {LINE_W{1'b0}}, 2);

      // Read hit on a buffered line, then a 5-cycle read miss.
      do_req(1'b1, 32'h300, rnd_line(), 2);
      do_req(1'b0, 32'h31C, {LINE_W{1'b0}}, 2);
      wait_empty();
      do_req(1'b0, 32'h800, {LINE_W{1'b0}}, 5);

      // Three back-to-back drains in order, then pointer wrap.
      do_req(1'b1, 32'hA00, rnd_line(), 2);
      do_req(1'b1, 32'hB00, rnd_line(), 2);
      do_req(1'b1, 32'hC00, rnd_line(), 2);
      wait_empty();
      for (int i = 0; i < 10; i++) begin
         do_req(1'b1, 32'h2000 + 32'(i) * 32'h40, rnd_line(), 1 + (i % 3));
         wait_empty();
      end

      // Reset in the middle of a drain.
      do_req(1'b1, 32'h4000, rnd_line(), 50);
      do_req(1'b1, 32'h4100, rnd_line(), 50);
      n = 0;
      while (!pmem_write && n < 10) begin
         tick();
         n++;
      end
      check_eq("drain_started", LINE_W'(pmem_write), LINE_W'(1));
      #2;
      reset = 1'b0;
      #1;
      check_eq("rst_drop_pmem", LINE_W'(pmem_write), LINE_W'(0));
      check_eq("rst_count", LINE_W'(ewb_count), LINE_W'(0));
      check_eq("rst_empty2", LINE_W'(ewb_empty), LINE_W'(1));
      addr_q.delete();
      data_q.delete();
      pmem_resp = 1'b0;
      lat_cnt   = 0;
      gap       = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("post_rst_quiet", LINE_W'(pmem_read | pmem_write), LINE_W'(0));
         chk_occ();
      end

      // Random traffic over eight lines with random offsets and memory latency.
      for (int i = 0; i < 300; i++) begin
         int op;
         logic [31:0] a;
         op = $urandom_range(0, 9);
         a  = 32'h0001_0000 + (32'($urandom_range(0, 7)) << 5) + 32'($urandom_range(0, 31));
         if (op < 4)      do_req(1'b0, a, {LINE_W{1'b0}}, $urandom_range(1, 4));
         else if (op < 8) do_req(1'b1, a, rnd_line(), $urandom_range(1, 4));
         else             idle($urandom_range(1, 8));
      end
      wait_empty();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ewb_multi.md
# ewb_multi

Multi-entry, parametrised eviction write buffer between the L2 cache and physical memory. Dirty evictions are absorbed into a DEPTH-entry circular FIFO and acknowledged in one cycle. Writes to a line already buffered coalesce in place, and reads that hit a buffered line are served without a memory access. Buffered lines drain to memory whenever the cache is not requesting.

## Interface
- DEPTH, 4: number of buffered lines, power of two, 2..16
- LINE_W, 256: line width in bits
- ADDR_W, 32: byte address width
- OFFSET_W, 5: line-offset bits; addresses are line-aligned internally (low OFFSET_W bits forced to 0)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- mem_read  in  1  cache read request, held until mem_resp
- mem_write  in  1  cache eviction request, held until mem_resp
- mem_address  in  ADDR_W  cache request address
- mem_wdata  in  LINE_W  eviction data
- mem_rdata  out  LINE_W  read data, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse to cache
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_address  out  ADDR_W  memory address, line-aligned
- pmem_wdata  out  LINE_W  head-entry data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory completion pulse
- ewb_count  out  $clog2(DEPTH+1)  occupied entries
- ewb_full  out  1  ewb_count==DEPTH
- ewb_empty  out  1  ewb_count==0

## Operation
- Storage: DEPTH entries {valid, line address, data}, head/tail pointers wrapping modulo DEPTH. Coalescing guarantees at most one valid entry per line address.
- FSM states: IDLE, WR_ACK, RD_HIT, RD_MEM, DRAIN.
- IDLE arbitration, highest priority first:
  - mem_read with address match: latch entry data, go to RD_HIT.
  - mem_read with no match: go to RD_MEM.
  - mem_write with match: overwrite that entry's data, go to WR_ACK. Count is unchanged.
  - mem_write, no match, not full: push at tail, count+1, go to WR_ACK.
  - mem_write, no match, full: go to DRAIN. The write is re-arbitrated after the drain completes.
  - No request and count>0: go to DRAIN.
  - Otherwise stay in IDLE.
- Simultaneous mem_read and mem_write is illegal. Read wins; the write is ignored until re-arbitrated.
- WR_ACK: mem_resp=1, then IDLE.
- RD_HIT: mem_resp=1, mem_rdata=latched entry data, then IDLE.
- RD_MEM: pmem_read=1, pmem_address=aligned mem_address, mem_rdata=pmem_rdata, mem_resp=pmem_resp (combinational pass-through). On pmem_resp, go to IDLE.
- DRAIN: pmem_write=1, pmem_address/pmem_wdata=head entry. On pmem_resp, clear the head valid bit, advance head, count−1, go to IDLE.
- A pmem transaction is never aborted. A request arriving during DRAIN waits for pmem_resp.
- Requester rule: the cache drops its request in the cycle after mem_resp. IDLE therefore never sees a stale request.
- Default outputs outside the listed states:
  - mem_resp=0, pmem_read=0, pmem_write=0.
  - pmem_address=aligned mem_address.
  - mem_rdata=pmem_rdata.
  - pmem_wdata=head data.

## Timing
- Reset asserted, any time, asynchronous:
  - State goes to IDLE; head, tail and count go to 0; all valid bits clear.
  - mem_resp=0, pmem_read=0, pmem_write=0, ewb_empty=1, ewb_full=0.
  - Data and address arrays are not reset.
  - Buffered lines are lost; an in-flight pmem request is dropped immediately.
- Write accept latency: request sampled at edge N, mem_resp high in cycle N+1.
- Read hit latency: same as write accept, 1 cycle.
- Read miss: mem_resp coincides with pmem_resp.
- Write when full with no match: one full pmem write, then 1 IDLE cycle, then WR_ACK.
- ewb_count/ewb_full/ewb_empty are registered and change on the edge that pushes or pops.
- Wrap-around: after DEPTH pushes, tail returns to 0. Pointer equality is disambiguated by count.

## Test plan
- Reset then idle -> ewb_empty=1, no pmem activity. Assert reset mid-DRAIN -> pmem_write falls immediately, ewb_count=0.
- Four writes (DEPTH=4) to 0x100, 0x200, 0x300, 0x400 with pmem_resp withheld -> each mem_resp 1 cycle after request, ewb_full=1 after the fourth. A fifth write to 0x500 -> DRAIN of 0x100 first, then accepted, count stays 4.
- Write 0x200 data A, then write 0x200 data B -> count=1. Drain performs one pmem_write with data B.
- Buffer 0x300 data C, read 0x300 -> mem_resp 1 cycle later with mem_rdata=C and pmem_read never asserted.
- Read miss 0x800 with pmem latency 5 -> pmem_read held 5 cycles, mem_resp and mem_rdata coincide with pmem_resp.
- Fill with 3 entries, then no requests -> three back-to-back drains in FIFO order, one IDLE cycle between each, ewb_empty=1 at the end. Push/pop 10 times -> pointers wrap correctly.
